// File: rtl/shift_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : shift_arbiter2
// Description : Two-port valid/ready sequencer that time-shares one 32-bit
//               logical-left shift unit. One operation is in flight at a
//               time: IDLE (accept) -> SHIFT (compute) -> RESP (return).
//               Round-robin priority when both requesters are valid, and
//               per-port saturating completion counters.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_arbiter2 #(
    parameter int RR_INIT = 0,   // port holding priority after reset (0 or 1)
    parameter int CNT_W   = 16   // width of the completion counters
) (
    input  logic             CLK,
    input  logic             RST,
    // port 0 request / response
    input  logic             ReqValid0,
    output logic             ReqReady0,
    input  logic [31:0]      ReqData0,
    input  logic [4:0]       ReqAmt0,
    output logic             RspValid0,
    input  logic             RspReady0,
    output logic [31:0]      RspData0,
    // port 1 request / response
    input  logic             ReqValid1,
    output logic             ReqReady1,
    input  logic [31:0]      ReqData1,
    input  logic [4:0]       ReqAmt1,
    output logic             RspValid1,
    input  logic             RspReady1,
    output logic [31:0]      RspData1,
    // status
    output logic             Busy,
    output logic [CNT_W-1:0] Count0,
    output logic [CNT_W-1:0] Count1
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic             c_rr_init = (RR_INIT != 0);
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t             r_state;
    logic               r_ptr;        // port that wins a tie next time
    logic               r_owner;      // port owning the in-flight operation
    logic [31:0]        r_data;       // latched operand
    logic [4:0]         r_amt;        // latched shift amount
    logic               r_busy;
    logic               r_rsp_valid0;
    logic               r_rsp_valid1;
    logic [31:0]        r_rsp_data0;
    logic [31:0]        r_rsp_data1;
    logic [CNT_W-1:0]   r_cnt0;
    logic [CNT_W-1:0]   r_cnt1;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic               w_idle;
    logic               w_grant0;
    logic               w_grant1;
    logic               w_rsp_fire;
    logic [31:0]        w_shift_res;

    // Stage k of the shifter holds the operand shifted by amt[k-1:0];
    // stage 0 is the latched operand itself.
    logic [31:0]        w_stage [0:5];

    // Arbitration only looks at the valids and the priority pointer, so the
    // ready outputs never depend on anything the requester derives from them.
    assign w_idle   = (r_state == ST_IDLE);
    assign w_grant0 = ReqValid0 && (!ReqValid1 || (r_ptr == 1'b0));
    assign w_grant1 = ReqValid1 && (!ReqValid0 || (r_ptr == 1'b1));

    assign ReqReady0 = w_idle && w_grant0;
    assign ReqReady1 = w_idle && w_grant1;

    // The non-owner's RspReady is deliberately ignored.
    assign w_rsp_fire = r_owner ? RspReady1 : RspReady0;

    // ------------------------------------------------------------------
    // Shift datapath: five-stage logarithmic left shifter driven only by
    // the latched operand/amount, so requester activity cannot disturb it.
    // Each stage conditionally shifts by 2**k with zero fill; bits pushed
    // past bit 31 fall off the top.
    // ------------------------------------------------------------------
    assign w_stage[0] = r_data;

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_shift_stage
            assign w_stage[gi+1] = r_amt[gi] ? (w_stage[gi] << (2 ** gi))
                                             : w_stage[gi];
        end
    endgenerate

    assign w_shift_res = w_stage[5];

    // ------------------------------------------------------------------
    // Sequencer: accept, compute, respond; all outputs except the ready
    // pair are registered here.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= ST_IDLE;
            r_ptr        <= c_rr_init;
            r_owner      <= 1'b0;
            r_data       <= 32'd0;
            r_amt        <= 5'd0;
            r_busy       <= 1'b0;
            r_rsp_valid0 <= 1'b0;
            r_rsp_valid1 <= 1'b0;
            r_rsp_data0  <= 32'd0;
            r_rsp_data1  <= 32'd0;
            r_cnt0       <= '0;
            r_cnt1       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // A grant is a completed request handshake; latch the
                    // winning port's operands and hand priority to the other.
                    if (w_grant0 || w_grant1) begin
                        r_data  <= w_grant1 ? ReqData1 : ReqData0;
                        r_amt   <= w_grant1 ? ReqAmt1  : ReqAmt0;
                        r_owner <= w_grant1;
                        r_ptr   <= ~w_grant1;
                        r_busy  <= 1'b1;
                        r_state <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    // Only the owner's result register is written; the other
                    // port keeps showing its last result.
                    if (r_owner) begin
                        r_rsp_data1  <= w_shift_res;
                        r_rsp_valid1 <= 1'b1;
                    end else begin
                        r_rsp_data0  <= w_shift_res;
                        r_rsp_valid0 <= 1'b1;
                    end
                    r_state <= ST_RESP;
                end

                ST_RESP: begin
                    // Hold the response until the owner takes it; count the
                    // completion without wrapping.
                    if (w_rsp_fire) begin
                        r_rsp_valid0 <= 1'b0;
                        r_rsp_valid1 <= 1'b0;
                        if (r_owner) begin
                            if (r_cnt1 != c_cnt_max) begin
                                r_cnt1 <= r_cnt1 + c_cnt_one;
                            end
                        end else begin
                            if (r_cnt0 != c_cnt_max) begin
                                r_cnt0 <= r_cnt0 + c_cnt_one;
                            end
                        end
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    // Unreachable encoding: recover to a clean idle.
                    r_rsp_valid0 <= 1'b0;
                    r_rsp_valid1 <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------
    assign RspValid0 = r_rsp_valid0;
    assign RspValid1 = r_rsp_valid1;
    assign RspData0  = r_rsp_data0;
    assign RspData1  = r_rsp_data1;
    assign Busy      = r_busy;
    assign Count0    = r_cnt0;
    assign Count1    = r_cnt1;

endmodule
`default_nettype wire

// File: tb/tb_shift_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_arbiter2
// Description : Directed, self-checking bench for shift_arbiter2. A table of
//               single-port operations plus hand-written sequences for
//               fairness, response back-pressure, mid-flight reset and
//               counter saturation (second instance with CNT_W=2, RR_INIT=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_arbiter2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // main instance (CNT_W=16, RR_INIT=0)
    logic        v0 = 0, v1 = 0, rr0 = 1, rr1 = 1;
    logic [31:0] d0 = 0, d1 = 0;
    logic [4:0]  a0 = 0, a1 = 0;
    logic        rdy0, rdy1, rv0, rv1, busy;
    logic [31:0] rd0, rd1;
    logic [15:0] cnt0, cnt1;

    shift_arbiter2 #(.RR_INIT(0), .CNT_W(16)) dut (
        .CLK(clk), .RST(rst),
        .ReqValid0(v0), .ReqReady0(rdy0), .ReqData0(d0), .ReqAmt0(a0),
        .RspValid0(rv0), .RspReady0(rr0), .RspData0(rd0),
        .ReqValid1(v1), .ReqReady1(rdy1), .ReqData1(d1), .ReqAmt1(a1),
        .RspValid1(rv1), .RspReady1(rr1), .RspData1(rd1),
        .Busy(busy), .Count0(cnt0), .Count1(cnt1)
    );

    // saturation instance (CNT_W=2, RR_INIT=1)
    logic        bv0 = 0, bv1 = 0;
    logic [31:0] bd0 = 0, bd1 = 0;
    logic [4:0]  ba0 = 0, ba1 = 0;
    logic        brdy0, brdy1, brv0, brv1, bbusy;
    logic [31:0] brd0, brd1;
    logic [1:0]  bcnt0, bcnt1;

    shift_arbiter2 #(.RR_INIT(1), .CNT_W(2)) dut_sat (
        .CLK(clk), .RST(rst),
        .ReqValid0(bv0), .ReqReady0(brdy0), .ReqData0(bd0), .ReqAmt0(ba0),
        .RspValid0(brv0), .RspReady0(1'b1), .RspData0(brd0),
        .ReqValid1(bv1), .ReqReady1(brdy1), .ReqData1(bd1), .ReqAmt1(ba1),
        .RspValid1(brv1), .RspReady1(1'b1), .RspData1(brd1),
        .Busy(bbusy), .Count0(bcnt0), .Count1(bcnt1)
    );

    int total = 0;
    int bad   = 0;

    // bench-side model of the main instance's result registers and counters
    logic [31:0] m_data0 = 0, m_data1 = 0;
    int          m_cnt0 = 0, m_cnt1 = 0;

    typedef struct {
        bit          port;
        logic [31:0] data;
        logic [4:0]  amt;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
        end
    endtask

    // One isolated operation on the main instance; entered just after a
    // falling edge in an IDLE cycle, leaves just after the falling edge of
    // the cycle following the response handshake.
    task automatic do_op(input bit p, input logic [31:0] d, input logic [4:0] a,
                         input logic [31:0] e);
        if (p) begin v1 = 1; d1 = d; a1 = a; end
        else   begin v0 = 1; d0 = d; a0 = a; end
        #1;
        chk("req_ready_owner", p ? rdy1 : rdy0, 1);
        chk("req_ready_other", p ? rdy0 : rdy1, 0);
        @(negedge clk);
        v0 = 0; v1 = 0; d0 = 32'h5555_5555; d1 = 32'h5555_5555; a0 = 5'd7; a1 = 5'd7;
        #1;
        chk("shift_busy", busy, 1);
        chk("shift_no_rsp", p ? rv1 : rv0, 0);
        @(negedge clk); #1;
        chk("rsp_valid_owner", p ? rv1 : rv0, 1);
        chk("rsp_valid_other", p ? rv0 : rv1, 0);
        chk("rsp_data_owner", p ? rd1 : rd0, e);
        chk("rsp_data_other", p ? rd0 : rd1, p ? m_data0 : m_data1);
        if (p) begin m_data1 = e; m_cnt1++; end
        else   begin m_data0 = e; m_cnt0++; end
        @(negedge clk); #1;
        chk("post_rsp_valid", p ? rv1 : rv0, 0);
        chk("post_busy", busy, 0);
        chk("count_owner", p ? cnt1 : cnt0, p ? m_cnt1 : m_cnt0);
    endtask

    initial begin
        vecs[0] = '{1'b0, 32'h0000_0001, 5'd31, 32'h8000_0000};
        vecs[1] = '{1'b1, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFF0};
        vecs[3] = '{1'b0, 32'h1234_5678, 5'd16, 32'h5678_0000};
        vecs[4] = '{1'b0, 32'hA5A5_A5A5, 5'd1,  32'h4B4B_4B4A};
        vecs[5] = '{1'b1, 32'h8000_0001, 5'd31, 32'h8000_0000};

        // ---- reset state ----
        @(negedge clk); @(negedge clk); #1;
        chk("rst_ready0", rdy0, 0);
        chk("rst_ready1", rdy1, 0);
        chk("rst_rv0", rv0, 0);
        chk("rst_rv1", rv1, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rd0", rd0, 0);
        chk("rst_rd1", rd1, 0);
        chk("rst_cnt0", cnt0, 0);
        chk("rst_cnt1", cnt1, 0);
        rst = 0;

        // ---- RR_INIT=1 instance gives the tie to port 1 ----
        bv0 = 1; bv1 = 1;
        #1;
        chk("rrinit1_ready1", brdy1, 1);
        chk("rrinit1_ready0", brdy0, 0);
        bv0 = 0; bv1 = 0;

        // ---- table-driven single-port operations ----
        for (int i = 0; i < 6; i++) begin
            do_op(vecs[i].port, vecs[i].data, vecs[i].amt, vecs[i].exp);
        end
        chk("table_cnt1", cnt1, 3);

        // ---- fairness: both continuously valid, pointer now at port 0 ----
        v0 = 1; d0 = 32'h1; a0 = 5'd1;
        v1 = 1; d1 = 32'h1; a1 = 5'd2;
        for (int g = 0; g < 4; g++) begin
            bit p;
            p = (g % 2) != 0;
            #1;
            chk("rr_ready0", rdy0, p ? 0 : 1);
            chk("rr_ready1", rdy1, p ? 1 : 0);
            @(negedge clk); @(negedge clk); #1;
            chk("rr_rsp_valid", p ? rv1 : rv0, 1);
            chk("rr_rsp_data", p ? rd1 : rd0, p ? 32'h4 : 32'h2);
            if (p) begin m_data1 = 32'h4; m_cnt1++; end
            else   begin m_data0 = 32'h2; m_cnt0++; end
            @(negedge clk);
        end
        v0 = 0; v1 = 0;
        #1;
        chk("rr_cnt0", cnt0, m_cnt0);
        chk("rr_cnt1", cnt1, m_cnt1);

        // ---- back-pressure on port 0 while port 1 waits ----
        rr0 = 0;
        v0 = 1; d0 = 32'h0000_00FF; a0 = 5'd8;
        #1;
        chk("bp_ready0", rdy0, 1);
        @(negedge clk);
        v0 = 0; v1 = 1; d1 = 32'h3; a1 = 5'd3;
        #1;
        chk("bp_shift_ready1", rdy1, 0);
        @(negedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            chk("bp_rv0", rv0, 1);
            chk("bp_rd0", rd0, 32'h0000_FF00);
            chk("bp_ready1", rdy1, 0);
            chk("bp_busy", busy, 1);
            @(negedge clk); #1;
        end
        rr0 = 1;
        #1;
        chk("bp_release_ready1", rdy1, 0);
        m_data0 = 32'h0000_FF00; m_cnt0++;
        @(negedge clk); #1;
        chk("bp_idle_ready1", rdy1, 1);
        chk("bp_idle_rv0", rv0, 0);
        chk("bp_cnt0", cnt0, m_cnt0);
        @(negedge clk);
        v1 = 0;
        @(negedge clk); #1;
        chk("bp_p1_rv1", rv1, 1);
        chk("bp_p1_rd1", rd1, 32'h18);
        m_cnt1++;
        @(negedge clk); #1;
        chk("bp_p1_cnt1", cnt1, m_cnt1);

        // ---- counter saturation on the CNT_W=2 instance ----
        for (int k = 0; k < 5; k++) begin
            bv0 = 1; bd0 = 32'(k + 1); ba0 = 5'(k);
            #1;
            chk("sat_ready0", brdy0, 1);
            @(negedge clk);
            bv0 = 0;
            @(negedge clk); #1;
            chk("sat_rv0", brv0, 1);
            chk("sat_rd0", brd0, 32'(k + 1) << k);
            @(negedge clk); #1;
            chk("sat_cnt0", bcnt0, (k < 3) ? (k + 1) : 3);
        end

        // ---- reset while in SHIFT (pointer was moved to port 1 by the grant) ----
        v0 = 1; d0 = 32'h5; a0 = 5'd2;
        #1;
        chk("rs_ready0", rdy0, 1);
        @(negedge clk);
        v0 = 0; rst = 1;
        #1;
        chk("rs_in_shift", busy, 1);
        @(negedge clk); #1;
        rst = 0;
        chk("rs_busy", busy, 0);
        chk("rs_rv0", rv0, 0);
        chk("rs_rv1", rv1, 0);
        chk("rs_cnt0", cnt0, 0);
        chk("rs_cnt1", cnt1, 0);
        chk("rs_rd0", rd0, 0);
        v0 = 1; v1 = 1;
        #1;
        chk("rs_ptr_ready0", rdy0, 1);
        chk("rs_ptr_ready1", rdy1, 0);
        v0 = 0; v1 = 0;
        @(negedge clk); @(negedge clk); #1;
        chk("rs_no_rsp", rv0, 0);
        chk("rs_still_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
